sub_pipe: RTL and testbench
===========================

Name: sub_pipe

Overview:
- Two-stage pipelined unsigned subtractor with borrow-in/borrow-out and valid/ready handshakes on both sides. Computes a - b - borrow.
- The carry chain is split: stage 1 resolves the low half, stage 2 resolves the high half using the registered low-half borrow.
- Companion to the combinational adder. Used in the Sobel datapath for gradient differences (pixel_right - pixel_left) and for wide counter/pointer differences where a full-width ripple chain would miss timing.

Parameters:
- WIDTH_P, 32, operand and result width; must be >= 2.
- LO_W (localparam), WIDTH_P/2, low-half width resolved in stage 1.
- HI_W (localparam), WIDTH_P-LO_W, high-half width resolved in stage 2.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- reset_i  input  1  synchronous, active-high reset.
- valid_i  input  1  upstream operands valid.
- ready_o  output  1  block can accept operands this cycle.
- a_i  input  WIDTH_P  minuend, unsigned.
- b_i  input  WIDTH_P  subtrahend, unsigned.
- borrow_i  input  1  borrow-in; subtracted at bit 0.
- valid_o  output  1  result valid.
- ready_i  input  1  downstream accepts result this cycle.
- diff_o  output  WIDTH_P  result, a_i - b_i - borrow_i mod 2^WIDTH_P.
- borrow_o  output  1  1 when a_i < b_i + borrow_i (unsigned underflow).

Behaviour:
- Arithmetic: a + ~b + ~borrow_i. Carry-in to bit 0 is ~borrow_i. borrow_o = ~carry_out of the MSB. Borrow between halves = ~carry out of bit LO_W-1.
- Stage 1 register s1 holds: valid, lo_diff[LO_W], lo_borrow, a_hi[HI_W], b_hi[HI_W].
- Stage 2 register s2 holds: valid, diff[WIDTH_P], borrow. s2 drives diff_o, borrow_o and valid_o directly, with no combinational path from inputs to outputs.
- Advance rules (elastic, no bubbles):
  - s2_en = ~s2.valid | ready_i
  - s1_en = ~s1.valid | s2_en
  - ready_o = s1_en & ~reset_i
- Input accepted when valid_i & ready_o.
  - On s1_en: s1.valid <= valid_i.
  - Data regs load only when valid_i & s1_en; otherwise they hold.
- On s2_en: s2.valid <= s1.valid. When s1.valid, load:
  - diff = {hi_diff, lo_diff}
  - borrow = hi borrow-out
  - hi_diff = a_hi + ~b_hi + ~lo_borrow
- Latency: 2 cycles from accept to valid_o with no backpressure. Throughput: 1 per cycle.
- Backpressure:
  - With valid_o=1 and ready_i=0, diff_o, borrow_o and valid_o hold stable.
  - s1 fills once more, then ready_o drops. Up to 2 results are buffered and none are lost or reordered.
- Simultaneous events: when both stages are full and ready_i=1 with valid_i=1, all three transfers occur in the same cycle.
- Reset: all valid bits and data regs clear to 0. valid_o=0, diff_o=0, borrow_o=0, ready_o=0 while reset_i=1, and ready_o=1 the cycle after release.
- Reset mid-operation: in-flight operands are discarded and no result is emitted afterwards.
- Boundaries:
  - 0 - 0 - 0 gives diff 0, borrow 0.
  - 0 - 0 - 1 gives diff all-ones, borrow 1.
  - all-ones - 0 gives all-ones, borrow 0.
  - Odd WIDTH_P puts the extra bit in the high half.

Optional Feature:
- Macro SUB_PIPE_SAT_EN.
- When defined: if the final borrow is 1, stage 2 loads diff = 0 (clamp at zero); borrow_o still reports 1. This supports magnitude-style unsigned gradients.
- When undefined: wrap-around modulo 2^WIDTH_P as specified above.
- Handshake, latency and reset behaviour are identical in both builds.

Test Plan:
- WIDTH_P=8, ready_i=1. Inputs:
  - 0x50-0x30, bin=0 -> 2 cycles later diff_o=0x20, borrow_o=0
  - 0x30-0x50 -> diff_o=0xE0, borrow_o=1 (SAT build: 0x00, borrow_o=1)
- Cross-half borrow: 0x10-0x01 -> 0x0F, borrow 0. 0x00-0x00 with bin=1 -> 0xFF, borrow 1. 0xFF-0xFF with bin=1 -> 0xFF, borrow 1.
- Back-to-back stream of 8 random pairs with valid_i held 1 -> 8 consecutive valid_o cycles matching the reference model, in order, first result at cycle +2.
- Backpressure: stream 5 operands, ready_i=0 for cycles 2-5 -> ready_o low once 2 are buffered, diff_o stable while stalled, all 5 results delivered in order after ready_i=1.
- Reset mid-stream: assert reset_i for 1 cycle with both stages full -> next cycle valid_o=0, diff_o=0, ready_o=1; no stale result appears later.
- Random valid_i/ready_i toggling for 10k cycles vs. a golden queue model -> zero mismatches. No change in diff_o while valid_o & ~ready_i.

Source files
------------

// File: rtl/sub_pipe.sv
// sub_pipe: two-stage elastic unsigned subtractor, diff = a - b - borrow.
// Stage 1 resolves the low half of the borrow chain, stage 2 the high half.
// Optional build macro SUB_PIPE_SAT_EN: clamp the result to zero on underflow.
module sub_pipe #(
    parameter int WIDTH_P = 32
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               valid_i,
    output logic               ready_o,
    input  logic [WIDTH_P-1:0] a_i,
    input  logic [WIDTH_P-1:0] b_i,
    input  logic               borrow_i,
    output logic               valid_o,
    input  logic               ready_i,
    output logic [WIDTH_P-1:0] diff_o,
    output logic               borrow_o
);
    localparam int LO_W = WIDTH_P / 2;
    localparam int HI_W = WIDTH_P - LO_W;

    typedef struct packed {
        logic            valid;
        logic [LO_W-1:0] lo_diff;
        logic            lo_borrow;
        logic [HI_W-1:0] a_hi;
        logic [HI_W-1:0] b_hi;
    } s1_t;

    typedef struct packed {
        logic               valid;
        logic [WIDTH_P-1:0] diff;
        logic               borrow;
    } s2_t;

    s1_t s1;
    s2_t s2;

    logic            s1_en, s2_en;
    logic [LO_W:0]   lo_sum;
    logic [HI_W:0]   hi_sum;
    logic            hi_borrow;

    // Each stage advances when it is empty or the stage after it drains.
    assign s2_en   = ~s2.valid | ready_i;
    assign s1_en   = ~s1.valid | s2_en;
    assign ready_o = s1_en & ~reset_i;

    // Subtraction as a + ~b + carry-in; a borrow is the inverted carry-out.
    assign lo_sum    = {1'b0, a_i[LO_W-1:0]} + {1'b0, ~b_i[LO_W-1:0]}
                     + {{LO_W{1'b0}}, ~borrow_i};
    assign hi_sum    = {1'b0, s1.a_hi} + {1'b0, ~s1.b_hi}
                     + {{HI_W{1'b0}}, ~s1.lo_borrow};
    assign hi_borrow = ~hi_sum[HI_W];

    // Stage 1: register the low-half result and the untouched high operands.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            s1 <= '0;
        end else if (s1_en) begin
            s1.valid <= valid_i;
            if (valid_i) begin
                s1.lo_diff   <= lo_sum[LO_W-1:0];
                s1.lo_borrow <= ~lo_sum[LO_W];
                s1.a_hi      <= a_i[WIDTH_P-1:LO_W];
                s1.b_hi      <= b_i[WIDTH_P-1:LO_W];
            end
        end
    end

    // Stage 2: finish the high half and hold the result until it is taken.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            s2 <= '0;
        end else if (s2_en) begin
            s2.valid <= s1.valid;
            if (s1.valid) begin
                s2.borrow <= hi_borrow;
`ifdef SUB_PIPE_SAT_EN
                s2.diff   <= hi_borrow ? '0 : {hi_sum[HI_W-1:0], s1.lo_diff};
`else
                s2.diff   <= {hi_sum[HI_W-1:0], s1.lo_diff};
`endif
            end
        end
    end

    assign valid_o  = s2.valid;
    assign diff_o   = s2.diff;
    assign borrow_o = s2.borrow;

endmodule

// File: tb/tb_sub_pipe.sv
// tb_sub_pipe: vector table, handshake corner sequences and a random
// stream checked against a queue of expected results.
module tb_sub_pipe;
    localparam int W = 8;
`ifdef SUB_PIPE_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic         clk, reset_i, valid_i, ready_o, borrow_i, valid_o, ready_i, borrow_o;
    logic [W-1:0] a_i, b_i, diff_o;

    sub_pipe #(.WIDTH_P(W)) dut (
        .clk_i(clk), .reset_i(reset_i), .valid_i(valid_i), .ready_o(ready_o),
        .a_i(a_i), .b_i(b_i), .borrow_i(borrow_i), .valid_o(valid_o),
        .ready_i(ready_i), .diff_o(diff_o), .borrow_o(borrow_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed { logic [W-1:0] d; logic bo; } res_t;
    typedef struct { logic [W-1:0] a; logic [W-1:0] b; logic bin; logic [W-1:0] d; logic bo; } vec_t;

    res_t         sb[$];
    int           tests = 0, fails = 0, npop = 0;
    bit           acc, stalled;
    logic [W-1:0] prev_d;
    logic         prev_bo;

    function automatic res_t model(input logic [W-1:0] a, b, input logic bin);
        logic [W:0] t;
        res_t r;
        t = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
        r.d  = (SAT && t[W]) ? '0 : t[W-1:0];
        r.bo = t[W];
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Handshake bookkeeping at the negative edge, where everything is settled.
    task automatic monitor();
        acc = 1'b0;
        if (reset_i) begin
            sb.delete();
            stalled = 1'b0;
            return;
        end
        if (stalled) begin
            chk("stall_valid", {31'b0, valid_o}, 32'd1);
            chk("stall_diff", {24'b0, diff_o}, {24'b0, prev_d});
            chk("stall_borrow", {31'b0, borrow_o}, {31'b0, prev_bo});
        end
        if (valid_o && ready_i) begin
            if (sb.size() == 0) begin
                chk("spurious_valid", 32'd1, 32'd0);
            end else begin
                res_t e;
                e = sb.pop_front();
                chk("sb_diff", {24'b0, diff_o}, {24'b0, e.d});
                chk("sb_borrow", {31'b0, borrow_o}, {31'b0, e.bo});
                npop++;
            end
        end
        if (valid_i && ready_o) begin
            sb.push_back(model(a_i, b_i, borrow_i));
            acc = 1'b1;
        end
        stalled = valid_o && !ready_i;
        prev_d  = diff_o;
        prev_bo = borrow_o;
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [W-1:0] a, b, input logic bin);
        a_i = a; b_i = b; borrow_i = bin;
    endtask

    vec_t tbl[7];

    initial begin
        int sent, n0;
        bit saw_low;
        tbl[0] = '{8'h50, 8'h30, 1'b0, 8'h20, 1'b0};
        tbl[1] = '{8'h30, 8'h50, 1'b0, 8'hE0, 1'b1};
        tbl[2] = '{8'h10, 8'h01, 1'b0, 8'h0F, 1'b0};
        tbl[3] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1};
        tbl[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        tbl[5] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        tbl[6] = '{8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0};

        reset_i = 1'b1; valid_i = 1'b0; ready_i = 1'b1; stalled = 1'b0;
        prev_d = '0; prev_bo = 1'b0;
        drive(8'h12, 8'h34, 1'b0);
        step(); step();
        chk("rst_valid_o", {31'b0, valid_o}, 32'd0);
        chk("rst_diff_o", {24'b0, diff_o}, 32'd0);
        chk("rst_borrow_o", {31'b0, borrow_o}, 32'd0);
        chk("rst_ready_o", {31'b0, ready_o}, 32'd0);
        reset_i = 1'b0;
        step();
        chk("post_rst_ready_o", {31'b0, ready_o}, 32'd1);

        // Directed vectors, one at a time, checked at exactly two cycles.
        foreach (tbl[i]) begin
            drive(tbl[i].a, tbl[i].b, tbl[i].bin);
            valid_i = 1'b1;
            step();
            valid_i = 1'b0;
            chk($sformatf("vec%0d_lat1_valid", i), {31'b0, valid_o}, 32'd0);
            step();
            chk($sformatf("vec%0d_valid", i), {31'b0, valid_o}, 32'd1);
            chk($sformatf("vec%0d_diff", i), {24'b0, diff_o},
                (SAT && tbl[i].bo) ? 32'd0 : {24'b0, tbl[i].d});
            chk($sformatf("vec%0d_borrow", i), {31'b0, borrow_o}, {31'b0, tbl[i].bo});
            step();
        end

        // Back-to-back stream of 8: results on eight consecutive cycles.
        n0 = npop;
        for (int i = 0; i < 11; i++) begin
            valid_i = (i < 8);
            drive(W'($urandom), W'($urandom), 1'($urandom));
            step();
            if (i >= 1 && i <= 8) chk($sformatf("b2b_valid_%0d", i), {31'b0, valid_o}, 32'd1);
            if (i == 0) chk("b2b_first_lat", {31'b0, valid_o}, 32'd0);
        end
        chk("b2b_count", npop - n0, 32'd8);

        // Backpressure: ready_i low on cycles 2-5 while pushing 5 operands.
        n0 = npop; sent = 0; saw_low = 1'b0;
        for (int c = 0; c < 40 && (sent < 5 || sb.size() != 0); c++) begin
            ready_i = !(c >= 2 && c <= 5);
            valid_i = (sent < 5);
            drive(W'($urandom), W'($urandom), 1'($urandom));
            #1;
            if (!ready_o) saw_low = 1'b1;
            step();
            if (acc) sent++;
        end
        valid_i = 1'b0; ready_i = 1'b1;
        chk("bp_ready_dropped", {31'b0, saw_low}, 32'd1);
        chk("bp_delivered", npop - n0, 32'd5);

        // Reset with both stages full: everything in flight is dropped.
        ready_i = 1'b0; valid_i = 1'b1;
        for (int c = 0; c < 10 && ready_o; c++) begin
            drive(W'($urandom), W'($urandom), 1'($urandom));
            step();
        end
        chk("full_before_rst", {31'b0, ready_o}, 32'd0);
        reset_i = 1'b1;
        step();
        reset_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
        #1;
        chk("midrst_valid_o", {31'b0, valid_o}, 32'd0);
        chk("midrst_diff_o", {24'b0, diff_o}, 32'd0);
        chk("midrst_ready_o", {31'b0, ready_o}, 32'd1);
        for (int c = 0; c < 5; c++) step();

        // Random handshake traffic against the expected-result queue.
        for (int c = 0; c < 10000; c++) begin
            valid_i = 1'($urandom);
            ready_i = ($urandom_range(0, 3) != 0);
            drive(W'($urandom), W'($urandom), 1'($urandom));
            step();
        end
        valid_i = 1'b0; ready_i = 1'b1;
        for (int c = 0; c < 10; c++) step();
        chk("final_sb_empty", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
